// File: rtl/frame_input_controller.sv
// Multi-key input controller: synchronises and debounces NUM_KEYS game keys, collects
// press edges per game frame and queues one interrupt word per frame for the CPU.
module frame_input_controller #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter logic [4:0]  IRQ_OPCODE      = 5'b11111
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                frame_rt_clk,
  input  logic                irq_ack,
  output logic [31:0]         interrupt_instruction,
  output logic                irq_valid,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                overflow
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] keys_meta_q, keys_sync_q;
  logic                frame_meta_q, frame_sync_q, frame_prev_q;
  logic [CW-1:0]       cnt_q [NUM_KEYS];
  logic [CW-1:0]       cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_state_q, key_state_d;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [10:0]         frame_cnt_q, frame_cnt_d;
  logic [31:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic [31:0]         head_q, head_d;
  logic                valid_q, valid_d;
  logic                overflow_q, overflow_d;

  logic [NUM_KEYS-1:0] press_s;
  logic                tick_s, pop_s, full_s, pend_any_s, push_s, ovf_set_s;
  logic [31:0]         push_word_s;

  // Per-key debounce: a new level must persist DEBOUNCE_CYCLES cycles before it is adopted.
  always_comb begin
    key_state_d = key_state_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = {CW{1'b0}};
      if (keys_sync_q[k] == key_state_q[k]) begin
        cnt_d[k] = {CW{1'b0}};
      end else if (cnt_q[k] == CNT_MAX) begin
        key_state_d[k] = ~key_state_q[k];
        cnt_d[k]       = {CW{1'b0}};
      end else begin
        cnt_d[k] = cnt_q[k] + CW'(1'b1);
      end
    end
  end

  assign press_s     = key_state_d & ~key_state_q;
  assign tick_s      = frame_sync_q & ~frame_prev_q;
  assign pop_s       = irq_ack & valid_q;
  assign full_s      = (count_q == DEPTH_C);
  assign pend_any_s  = |pending_q;
  assign push_s      = tick_s & pend_any_s & (~full_s | pop_s);
  assign ovf_set_s   = tick_s & pend_any_s & full_s & ~pop_s;
  assign push_word_s = {IRQ_OPCODE, frame_cnt_q, 16'(pending_q)};

  // Frame bookkeeping and FIFO pointer/occupancy update.
  always_comb begin
    pending_d   = (push_s ? {NUM_KEYS{1'b0}} : pending_q) | press_s;
    frame_cnt_d = tick_s ? (frame_cnt_q + 11'd1) : frame_cnt_q;
    wr_ptr_d    = push_s ? (wr_ptr_q + AW'(1'b1)) : wr_ptr_q;
    rd_ptr_d    = pop_s ? (rd_ptr_q + AW'(1'b1)) : rd_ptr_q;
    overflow_d  = overflow_q | ovf_set_s;
    count_d     = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1'b1);
      2'b01:   count_d = count_q - (AW + 1)'(1'b1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != {(AW + 1){1'b0}});
  end

  // Next head word; the word being written may become the head in the same cycle.
  always_comb begin
    head_d = 32'h0000_0000;
    if (!valid_d) begin
      head_d = 32'h0000_0000;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_word_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      keys_meta_q  <= {NUM_KEYS{1'b0}};
      keys_sync_q  <= {NUM_KEYS{1'b0}};
      frame_meta_q <= 1'b0;
      frame_sync_q <= 1'b0;
      frame_prev_q <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= {CW{1'b0}};
      end
      key_state_q <= {NUM_KEYS{1'b0}};
      pending_q   <= {NUM_KEYS{1'b0}};
      frame_cnt_q <= 11'd0;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {(AW + 1){1'b0}};
      head_q      <= 32'h0000_0000;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      keys_meta_q  <= keys;
      keys_sync_q  <= keys_meta_q;
      frame_meta_q <= frame_rt_clk;
      frame_sync_q <= frame_meta_q;
      frame_prev_q <= frame_sync_q;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      key_state_q <= key_state_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only observed through the pointers.
  always_ff @(posedge sysclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_word_s;
    end
  end

  assign interrupt_instruction = head_q;
  assign irq_valid             = valid_q;
  assign key_state             = key_state_q;
  assign overflow              = overflow_q;

endmodule

// File: tb/tb_frame_input_controller.sv
// Directed bench for frame_input_controller; queued words are checked by a scoreboard
// monitor that acknowledges and compares whenever the DUT offers a word.
module tb_frame_input_controller;

  logic        sysclk       = 1'b0;
  logic        reset        = 1'b0;
  logic [3:0]  keys         = 4'h0;
  logic        frame_rt_clk = 1'b0;
  logic        irq_ack      = 1'b0;
  logic [31:0] interrupt_instruction;
  logic        irq_valid;
  logic [3:0]  key_state;
  logic        overflow;

  int          checks     = 0;
  int          errors     = 0;
  int          ack_budget = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_w;
  logic [31:0] ovf_words [4];

  frame_input_controller #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(16), .FIFO_DEPTH(4), .IRQ_OPCODE(5'b11111)
  ) dut (
    .sysclk(sysclk), .reset(reset), .keys(keys), .frame_rt_clk(frame_rt_clk),
    .irq_ack(irq_ack), .interrupt_instruction(interrupt_instruction),
    .irq_valid(irq_valid), .key_state(key_state), .overflow(overflow)
  );

  always #5 sysclk = ~sysclk;

  task automatic cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic frame_pulse();
    frame_rt_clk = 1'b1;
    cyc(4);
    frame_rt_clk = 1'b0;
    cyc(4);
  endtask

  task automatic press_key(input int k);
    keys[k] = 1'b1;
    cyc(20);
    keys[k] = 1'b0;
    cyc(20);
  endtask

  // Monitor: acknowledge offered words while the stimulus grants acks, comparing each.
  always @(negedge sysclk) begin
    if (ack_budget > 0 && irq_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: got %h expected no word", interrupt_instruction);
      end else begin
        exp_w = sb.pop_front();
        if (interrupt_instruction !== exp_w) begin
          errors++;
          $display("FAIL scoreboard: got %h expected %h", interrupt_instruction, exp_w);
        end
      end
      irq_ack    = 1'b1;
      ack_budget = ack_budget - 1;
    end else begin
      irq_ack = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    ovf_words[0] = 32'hF808_0008;
    ovf_words[1] = 32'hF809_0008;
    ovf_words[2] = 32'hF80A_0008;
    ovf_words[3] = 32'hF80B_0008;

    // reset with all keys held
    keys  = 4'hF;
    reset = 1'b0;
    cyc(3);
    check("rst_key_state", 32'(key_state), 32'h0);
    check("rst_irq_valid", 32'(irq_valid), 32'h0);
    check("rst_instr", interrupt_instruction, 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    reset = 1'b1;
    cyc(17);
    check("rel_key_state_17", 32'(key_state), 32'h0);
    cyc(1);
    check("rel_key_state_18", 32'(key_state), 32'hF);
    check("idle_irq_valid", 32'(irq_valid), 32'h0);
    check("idle_instr", interrupt_instruction, 32'h0);
    keys  = 4'h0;
    reset = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(3);

    // four empty frames: frame_cnt 0..3, nothing pushed
    repeat (4) frame_pulse();
    check("empty_frames_valid", 32'(irq_valid), 32'h0);

    // short glitch must be rejected
    keys[0] = 1'b1;
    cyc(10);
    keys[0] = 1'b0;
    cyc(25);
    check("glitch_key_state", 32'(key_state), 32'h0);
    frame_pulse();
    check("glitch_no_word", 32'(irq_valid), 32'h0);

    // stable press: exactly 18 cycles latency
    keys[0] = 1'b1;
    cyc(17);
    check("deb_key0_17", 32'(key_state), 32'h0);
    cyc(1);
    check("deb_key0_18", 32'(key_state), 32'h1);
    keys[2] = 1'b1;
    cyc(20);
    check("deb_key02", 32'(key_state), 32'h5);

    // frame 5 packages mask 0101
    sb.push_back(32'hF805_0005);
    frame_pulse();
    check("pkg_valid", 32'(irq_valid), 32'h1);
    check("pkg_word", interrupt_instruction, 32'hF805_0005);
    ack_budget = 1;
    cyc(2);
    check("pkg_ack_valid", 32'(irq_valid), 32'h0);
    check("pkg_ack_instr", interrupt_instruction, 32'h0);

    // press edge coinciding with the tick lands in the next frame (frame 6 empty)
    keys = 4'h0;
    cyc(25);
    keys[1] = 1'b1;
    cyc(15);
    frame_rt_clk = 1'b1;
    cyc(4);
    frame_rt_clk = 1'b0;
    cyc(4);
    check("coin_key_state", 32'(key_state), 32'h2);
    check("coin_no_word", 32'(irq_valid), 32'h0);
    sb.push_back(32'hF807_0002);
    frame_pulse();
    check("coin_next_valid", 32'(irq_valid), 32'h1);
    ack_budget = 1;
    cyc(2);
    check("coin_drained", 32'(irq_valid), 32'h0);
    keys[1] = 1'b0;
    cyc(25);

    // fill the FIFO with frames 8..11
    for (int i = 0; i < 4; i++) begin
      press_key(3);
      sb.push_back(ovf_words[i]);
      frame_pulse();
    end
    check("fill_valid", 32'(irq_valid), 32'h1);
    check("fill_no_overflow", 32'(overflow), 32'h0);
    // frame 12 deferred
    press_key(3);
    frame_pulse();
    check("ovf_set", 32'(overflow), 32'h1);
    press_key(0);
    ack_budget = 1;
    cyc(3);
    check("ovf_after_ack_valid", 32'(irq_valid), 32'h1);
    // retained key3 merges with key0 in frame 13
    sb.push_back(32'hF80D_0009);
    frame_pulse();
    check("ovf_sticky", 32'(overflow), 32'h1);

    // push and pop in the same cycle while full (frame 14)
    press_key(2);
    sb.push_back(32'hF80E_0004);
    frame_rt_clk = 1'b1;
    cyc(2);
    ack_budget = 1;
    cyc(2);
    frame_rt_clk = 1'b0;
    cyc(4);
    check("simul_valid", 32'(irq_valid), 32'h1);
    check("simul_overflow", 32'(overflow), 32'h1);
    ack_budget = 4;
    cyc(8);
    check("drain_empty", 32'(irq_valid), 32'h0);
    check("drain_instr", interrupt_instruction, 32'h0);
    check("drain_budget_used", 32'(ack_budget), 32'h0);

    // reset mid-operation discards the queued word and overflow
    press_key(1);
    frame_pulse();
    check("pre_rst_word", interrupt_instruction, 32'hF80F_0002);
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    check("mid_rst_valid", 32'(irq_valid), 32'h0);
    check("mid_rst_instr", interrupt_instruction, 32'h0);
    check("mid_rst_overflow", 32'(overflow), 32'h0);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_input_controller.md
Name: frame_input_controller

Overview:
- Parametrised successor to the single-key input controller. Accepts NUM_KEYS raw game keys (jump, duck, pause, …), then synchronises and debounces each key and latches press edges.
- Once per game frame it packages the pressed-key mask into one interrupt instruction and queues it in a small FIFO. The CPU consumes the FIFO through a valid/ack handshake.
- Sits between the board pushbuttons, the 60 fps frame-rate divider and the CPU interrupt_instruction input.

Parameters:
- NUM_KEYS, 4, number of key channels (1..16).
- DEBOUNCE_CYCLES, 16, number of consecutive sysclk cycles a synchronised key must hold a new level before the debounced state changes (>=2).
- FIFO_DEPTH, 4, interrupt words buffered (power of 2, >=2).
- IRQ_OPCODE, 5'b11111, opcode placed in bits [31:27] of every interrupt word.

Ports:
- sysclk  in  1  system clock; all state is clocked on its rising edge.
- reset  in  1  synchronous, active-low reset.
- keys  in  NUM_KEYS  raw asynchronous key levels, 1 = pressed.
- frame_rt_clk  in  1  frame-rate clock from the divider; treated as asynchronous.
- irq_ack  in  1  CPU has consumed the current word; pops the FIFO.
- interrupt_instruction  out  32  head FIFO word when irq_valid=1, else 32'h0 (nop).
- irq_valid  out  1  FIFO not empty.
- key_state  out  NUM_KEYS  debounced key levels.
- overflow  out  1  sticky: a frame event was deferred because the FIFO was full.

Behaviour:
- Reset (reset=0 at a sysclk edge):
  - All synchronisers, debounce counters, key_state, pending mask, frame counter, FIFO pointers and overflow go to 0.
  - Outputs therefore read interrupt_instruction=0, irq_valid=0, key_state=0, overflow=0.
  - Reset asserted mid-operation discards queued words and pending presses.
- Synchronisation: each keys bit and frame_rt_clk passes through a 2-flop synchroniser.
- Debounce, per key:
  - 0-based counter cnt.
  - If the synchronised level equals key_state: cnt<=0.
  - Else, if cnt==DEBOUNCE_CYCLES-1: key_state flips and cnt<=0.
  - Else: cnt<=cnt+1.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change key_state.
  - Latency from a raw edge to key_state change is 2+DEBOUNCE_CYCLES cycles.
- Press edge: a press is key_state rising (0->1) for one cycle. Releases generate no event.
- Frame tick:
  - One-cycle pulse on the rising edge of the synchronised frame_rt_clk.
  - frame_cnt (11 bits) increments on every tick and wraps 2047->0.
- Pending mask update each cycle: pending <= (push ? 0 : pending) | press.
  - A press in the same cycle as a tick lands in the next frame.
  - Multiple presses of one key within a frame collapse to one bit.
- Push:
  - Occurs when tick=1 AND pending!=0 AND (FIFO not full OR pop in the same cycle).
  - Pushed word fields:
    - [31:27] = IRQ_OPCODE.
    - [26:16] = frame_cnt value before its increment.
    - [15:0] = pending, zero-extended.
  - A tick with pending==0 pushes nothing.
- Full FIFO:
  - If tick=1, pending!=0, FIFO full and no pop: no push, pending is retained, overflow<=1.
  - Retained presses merge into the next frame; no presses are lost. overflow stays set until reset.
- Pop: when irq_ack=1 and irq_valid=1. irq_ack while empty is ignored.
- Simultaneous push and pop are legal at any occupancy, including full and empty.
- Output timing:
  - irq_valid and interrupt_instruction are registered FIFO state.
  - A pushed word is visible the cycle after the push.
  - After a pop, the next word (or 0) is visible the following cycle.
- Occupancy counter is log2(FIFO_DEPTH)+1 bits; read and write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with keys=4'hF. Release reset → key_state=0 on release. key_state=4'hF after 18 more cycles. Before any tick: irq_valid=0 and interrupt_instruction=0.
- Debounce: pulse keys[0]=1 for 10 cycles (DEBOUNCE_CYCLES=16) → key_state[0] stays 0 and no word is queued. Hold 20 cycles → key_state[0]=1 exactly 18 cycles after the raw edge.
- Frame packaging: press keys 0 and 2 stably, then raise frame_rt_clk with frame_cnt=5. Required word: opcode 11111, frame field 5, mask 4'b0101, i.e. 32'hF8050005, with irq_valid=1. irq_ack → irq_valid=0 next cycle.
- Press/tick coincidence: force the press edge into the tick cycle → no word that frame. The next tick pushes the mask containing that key.
- Overflow: no ack, press a key and tick 5 times with FIFO_DEPTH=4 → 4 words queued and overflow=1 after the 5th tick. Ack once, then tick again → 5th word pushed with the retained mask and the current frame_cnt.
- Simultaneous push/pop at full: ack in the tick cycle with pending!=0 → occupancy stays 4, overflow unchanged, word order preserved.
